// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: controller states and the
// register map seen on the peripheral write bus.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_DUTY   = 2'd2;

   localparam int CTRL_EN_BIT = 0;

endpackage

// File: rtl/pwm_ctrl.sv
// PWM sequencing controller: runs a period counter from software-written
// PERIOD/DUTY registers and emits one-cycle set/reset pulses for the
// output SR latch that lives beside this block in the peripheral top.
module pwm_ctrl
   import pwm_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [1:0]       wr_addr,
   input  logic [CNT_W-1:0] wr_data,
   output logic             set_pulse,
   output logic             reset_pulse,
   output logic             period_done,
   output logic             running,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   state_t           state;
   logic             en_stg;
   logic [CNT_W-1:0] per_stg;
   logic [CNT_W-1:0] duty_stg;
   logic [CNT_W-1:0] per_act;
   logic [CNT_W-1:0] duty_act;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] per_eff;
   logic             at_last;

   // Staging registers take bus writes immediately; the counter only sees them at a period start.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_stg   <= 1'b0;
         per_stg  <= '1;
         duty_stg <= '0;
      end else if (wr_en) begin
         case (wr_addr)
            ADDR_CTRL:   en_stg   <= wr_data[CTRL_EN_BIT];
            ADDR_PERIOD: per_stg  <= wr_data;
            ADDR_DUTY:   duty_stg <= wr_data;
            default:     ;
         endcase
      end
   end

   // Periods below two are stretched to two so the set and reset counts can never coincide.
   always_comb begin
      per_eff = (per_act < MIN_PERIOD) ? MIN_PERIOD : per_act;
      at_last = (cnt_q == (per_eff - ONE));
   end

   // Sequencer: IDLE waits for enable, RUN counts and reloads at each wrap, STOP is a one-cycle shutdown.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt_q    <= '0;
         per_act  <= '1;
         duty_act <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_q <= '0;
               if (en_stg) begin
                  state    <= RUN;
                  per_act  <= per_stg;
                  duty_act <= duty_stg;
               end
            end
            RUN: begin
               if (!en_stg) begin
                  state <= STOP;
               end else if (at_last) begin
                  cnt_q    <= '0;
                  per_act  <= per_stg;
                  duty_act <= duty_stg;
               end else begin
                  cnt_q <= cnt_q + ONE;
               end
            end
            STOP: begin
               state <= IDLE;
               cnt_q <= '0;
            end
            default: begin
               state <= IDLE;
               cnt_q <= '0;
            end
         endcase
      end
   end

   // Pulse decode from registered state only, so each pulse is exactly one count wide.
   always_comb begin
      set_pulse   = 1'b0;
      reset_pulse = 1'b0;
      period_done = 1'b0;
      case (state)
         RUN: begin
            set_pulse   = (cnt_q == '0) && (duty_act != '0);
            reset_pulse = ((duty_act == '0) && (cnt_q == '0)) ||
                          ((duty_act != '0) && (cnt_q == duty_act) && (duty_act < per_eff));
            period_done = at_last;
         end
         STOP: begin
            reset_pulse = 1'b1;
         end
         default: ;
      endcase
   end

   assign running = (state == RUN);
   assign cnt     = cnt_q;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Self-checking bench for pwm_ctrl: directed scenarios followed by random
// register traffic, all compared against a behavioural period/duty model
// plus a model of the SR latch the controller drives.
module tb_pwm_ctrl;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_STOP = 2;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [15:0] wr_data;
   logic        set_pulse;
   logic        reset_pulse;
   logic        period_done;
   logic        running;
   logic [15:0] cnt;

   int tests_run;
   int tests_failed;

   // behavioural model state
   int m_mode;
   int m_cnt;
   int m_en;
   int m_per_s;
   int m_duty_s;
   int m_per_a;
   int m_duty_a;

   // SR latch model driven by the DUT pulses
   bit   q_reg;
   logic latch_q;

   // values sampled at the last check point
   bit s_lvl;
   bit s_reset;
   bit s_done;
   int s_cnt;

   pwm_ctrl #(.CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .set_pulse   (set_pulse),
      .reset_pulse (reset_pulse),
      .period_done (period_done),
      .running     (running),
      .cnt         (cnt)
   );

   // free-running clock, 10 time units per cycle
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // combinational latch: set wins, reset clears, otherwise hold
   assign latch_q = set_pulse ? 1'b1 : (reset_pulse ? 1'b0 : q_reg);

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      m_mode   = M_IDLE;
      m_cnt    = 0;
      m_en     = 0;
      m_per_s  = 16'hFFFF;
      m_duty_s = 0;
      m_per_a  = 16'hFFFF;
      m_duty_a = 0;
      q_reg    = 1'b0;
   endtask

   // expected outputs: the latch is high over counts [0, duty) of each period
   task automatic checkOutput();
      int peff;
      bit e_set, e_rst, e_done, e_run, e_lvl;
      e_set = 0; e_rst = 0; e_done = 0; e_run = 0; e_lvl = 0;
      peff  = (m_per_a < 2) ? 2 : m_per_a;
      if (m_mode == M_RUN) begin
         e_run  = 1;
         e_set  = (m_duty_a > 0) && (m_cnt == 0);
         e_rst  = (m_duty_a < peff) && (m_cnt == m_duty_a);
         e_done = (m_cnt == peff - 1);
         e_lvl  = (m_duty_a > 0) && (m_cnt < m_duty_a);
      end else if (m_mode == M_STOP) begin
         e_rst = 1;
      end
      s_lvl   = latch_q;
      s_reset = reset_pulse;
      s_done  = period_done;
      s_cnt   = int'(cnt);
      checkVal("set_pulse",   set_pulse,   e_set);
      checkVal("reset_pulse", reset_pulse, e_rst);
      checkVal("period_done", period_done, e_done);
      checkVal("running",     running,     e_run);
      checkVal("cnt",         cnt,         m_cnt);
      checkVal("latch_level", latch_q,     e_lvl);
   endtask

   // advance the model across one rising edge using the inputs held before it
   task automatic modelEdge(input bit we, input int a, input int d, input bit r);
      int peff;
      int nxt;
      if (r) begin
         modelReset();
         return;
      end
      q_reg = s_lvl;
      peff  = (m_per_a < 2) ? 2 : m_per_a;
      if (m_mode == M_IDLE) begin
         m_cnt = 0;
         if (m_en != 0) begin
            m_mode   = M_RUN;
            m_per_a  = m_per_s;
            m_duty_a = m_duty_s;
         end
      end else if (m_mode == M_RUN) begin
         if (m_en == 0) begin
            m_mode = M_STOP;
         end else begin
            nxt = (m_cnt + 1) % peff;
            if (nxt == 0) begin
               m_per_a  = m_per_s;
               m_duty_a = m_duty_s;
            end
            m_cnt = nxt;
         end
      end else begin
         m_mode = M_IDLE;
         m_cnt  = 0;
      end
      if (we) begin
         if (a == 0) m_en = d & 1;
         else if (a == 1) m_per_s = d & 16'hFFFF;
         else if (a == 2) m_duty_s = d & 16'hFFFF;
      end
   endtask

   // one clock cycle: drive, check at the falling edge, then step the model
   task automatic applyStimulus(input bit we, input int a, input int d, input bit r);
      wr_en   = we;
      wr_addr = a[1:0];
      wr_data = d[15:0];
      rst     = r;
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      modelEdge(we, a, d, r);
      #1;
      wr_en = 1'b0;
      rst   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0);
   endtask

   task automatic busWrite(input int a, input int d);
      applyStimulus(1'b1, a, d, 1'b0);
   endtask

   // idle until the next cycle will show the given count in RUN
   task automatic waitCnt(input int target);
      int guard;
      guard = 0;
      while (!(m_mode == M_RUN && m_cnt == target) && guard < 64) begin
         idle(1);
         guard++;
      end
      checkVal("wait_cnt_timeout", guard < 64, 1'b1);
   endtask

   // number of latch-high cycles over n cycles starting at a period start
   task automatic measureHigh(input int n, input int exp);
      int high;
      high = 0;
      waitCnt(0);
      for (int i = 0; i < n; i++) begin
         idle(1);
         high += int'(s_lvl);
      end
      checkVal("high_count", high, exp);
   endtask

   // count at which reset_pulse fires in the next 10-count period
   task automatic findReset(input int exp);
      int where;
      where = -1;
      waitCnt(0);
      for (int i = 0; i < 10; i++) begin
         idle(1);
         if (s_reset && where < 0) where = s_cnt;
      end
      checkVal("reset_position", where, exp);
   endtask

   initial begin
      int a, d;
      bit we, r;
      tests_run    = 0;
      tests_failed = 0;
      modelReset();
      s_lvl = 0; s_reset = 0; s_done = 0; s_cnt = 0;
      rst = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'd0;
      @(posedge clk);
      #1;

      // reset state
      applyStimulus(1'b0, 0, 0, 1'b1);
      idle(2);
      checkVal("reset_per_stg", dut.per_stg, 16'hFFFF);

      // PERIOD=10, DUTY=3
      busWrite(1, 10);
      busWrite(2, 3);
      busWrite(0, 1);
      idle(1);
      checkVal("start_set", set_pulse, 1'b1);
      idle(22);
      measureHigh(10, 3);
      findReset(3);

      // mid-period DUTY change 3 -> 7 at cnt=5, then a write on the wrap cycle
      waitCnt(5);
      busWrite(2, 7);
      findReset(7);
      waitCnt(9);
      busWrite(2, 3);
      findReset(7);
      findReset(3);

      // disable at cnt=4, one STOP cycle, then re-enable
      waitCnt(4);
      busWrite(0, 0);
      idle(2);
      checkVal("stop_reset_pulse", s_reset, 1'b1);
      idle(3);
      busWrite(0, 1);
      idle(14);

      // PERIOD=8 with DUTY=0 (always low) and DUTY=12 (always high)
      busWrite(1, 8);
      busWrite(2, 0);
      idle(20);
      measureHigh(8, 0);
      busWrite(2, 12);
      idle(10);
      measureHigh(8, 8);

      // PERIOD=1 behaves as 2
      busWrite(1, 1);
      busWrite(2, 1);
      idle(12);
      waitCnt(1);
      idle(1);
      checkVal("short_period_done", s_done, 1'b1);

      // rst at cnt=6 in RUN
      busWrite(1, 10);
      busWrite(2, 3);
      waitCnt(6);
      applyStimulus(1'b0, 0, 0, 1'b1);
      checkVal("rst_per_stg", dut.per_stg, 16'hFFFF);
      checkVal("rst_en_stg", dut.en_stg, 1'b0);
      idle(10);

      // random register traffic against the model
      for (int i = 0; i < 500; i++) begin
         r  = ($urandom_range(0, 199) == 0);
         we = ($urandom_range(0, 3) == 0);
         a  = int'($urandom_range(0, 3));
         if (a == 0)      d = int'($urandom & 32'hFFFE) | (($urandom_range(0, 9) < 8) ? 1 : 0);
         else if (a == 1) d = int'($urandom_range(0, 14));
         else             d = int'($urandom_range(0, 16));
         d = d & 16'hFFFF;
         applyStimulus(we, a, d, r);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
